// File: rtl/io_master.sv
// io_master: bus initiator for the memory-mapped switch/LED IO peripheral.
//
// On start it polls the peripheral status register until switch data is
// ready, then reads the switch low and high bytes. It combines them with
// the operation selected by OP and writes the 12-bit result to the LED
// register. If status never becomes ready within POLL_MAX polls, it raises
// a sticky error flag and makes no LED write.
//
// Optional feature (compile-time macro IO_MASTER_WAIT_ACK_EN): after the
// LED write, poll status bit 0 until the operator latches the LED. The same
// POLL_MAX timeout applies; a timeout here leaves the LED already written.
//
// Parameters:
//   OP        byte operation: 0 hi+lo, 1 hi-lo, 2 hi*lo, 3 {hi[3:0],lo}
//   POLL_MAX  status polls allowed before timeout (>= 1)
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   start       begin a transaction (sampled only in IDLE)
//   pRead       read strobe to the peripheral
//   pWrite      write strobe to the peripheral
//   addr        register select: 00 status, 01 LED, 10 switch lo, 11 switch hi
//   pWriteData  LED write data (mirrors result)
//   pReadData   read data, combinational from the peripheral
//   busy        high in every state except IDLE
//   done        one-cycle pulse on successful completion
//   error       sticky timeout flag, cleared by the next accepted start
//   result      last computed result
module io_master #(
  parameter int unsigned OP       = 2,
  parameter int unsigned POLL_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        pRead,
  output logic        pWrite,
  output logic [1:0]  addr,
  output logic [11:0] pWriteData,
  input  logic [31:0] pReadData,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [11:0] result
);

  localparam int unsigned CntW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(POLL_MAX - 1);

  localparam logic [1:0] AddrStatus = 2'b00;
  localparam logic [1:0] AddrLed    = 2'b01;
  localparam logic [1:0] AddrSwLo   = 2'b10;
  localparam logic [1:0] AddrSwHi   = 2'b11;

  typedef enum logic [3:0] {
    StIdle,
    StPoll,
    StRdLo,
    StRdHi,
    StExec,
    StWr,
    StDone,
    StErr,
    StWaitAck
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      lo_q, lo_d;
  logic [7:0]      hi_q, hi_d;
  logic [11:0]     result_q, result_d;
  logic            error_q, error_d;

  logic            pread_q, pread_d;
  logic            pwrite_q, pwrite_d;
  logic [1:0]      addr_q, addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [11:0]     op_result;

  // Only the low byte and the two status bits carry information.
  logic unused_rdata;
  assign unused_rdata = ^{pReadData[31:8], pReadData[0]};

  // Byte operation; OP is fixed at elaboration so only one arm survives.
  always_comb begin
    case (OP)
      0:       op_result = {3'b000, ({1'b0, hi_q} + {1'b0, lo_q})};
      1:       op_result = {4'h0, hi_q} - {4'h0, lo_q};
      // 12-bit product equals the low 12 bits of the full 16-bit product.
      2:       op_result = {4'h0, hi_q} * {4'h0, lo_q};
      default: op_result = {hi_q[3:0], lo_q};
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    result_d = result_q;
    error_d  = error_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPoll;
          cnt_d   = '0;
          error_d = 1'b0;
        end
      end
      StPoll: begin
        if (pReadData[1]) begin
          state_d = StRdLo;
        end else if (cnt_q == CntMax) begin
          state_d = StErr;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRdLo: begin
        lo_d    = pReadData[7:0];
        state_d = StRdHi;
      end
      StRdHi: begin
        hi_d    = pReadData[7:0];
        state_d = StExec;
      end
      StExec: begin
        result_d = op_result;
        state_d  = StWr;
      end
      StWr: begin
`ifdef IO_MASTER_WAIT_ACK_EN
        state_d = StWaitAck;
        cnt_d   = '0;
`else
        state_d = StDone;
`endif
      end
`ifdef IO_MASTER_WAIT_ACK_EN
      StWaitAck: begin
        if (pReadData[0]) begin
          state_d = StDone;
        end else if (cnt_q == CntMax) begin
          state_d = StErr;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StDone: state_d = StIdle;
      StErr:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs are decoded from the next state and registered, so each
  // strobe/address is stable for the whole cycle of the state it belongs to.
  always_comb begin
    pread_d  = 1'b0;
    pwrite_d = 1'b0;
    addr_d   = AddrStatus;
    done_d   = 1'b0;
    busy_d   = (state_d != StIdle);

    unique case (state_d)
      StPoll: pread_d = 1'b1;
      StRdLo: begin
        pread_d = 1'b1;
        addr_d  = AddrSwLo;
      end
      StRdHi: begin
        pread_d = 1'b1;
        addr_d  = AddrSwHi;
      end
      StWr: begin
        pwrite_d = 1'b1;
        addr_d   = AddrLed;
      end
`ifdef IO_MASTER_WAIT_ACK_EN
      StWaitAck: pread_d = 1'b1;
`endif
      StDone: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      pread_q  <= 1'b0;
      pwrite_q <= 1'b0;
      addr_q   <= AddrStatus;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      result_q <= result_d;
      error_q  <= error_d;
      pread_q  <= pread_d;
      pwrite_q <= pwrite_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign pRead      = pread_q;
  assign pWrite     = pwrite_q;
  assign addr       = addr_q;
  assign pWriteData = result_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign result     = result_q;

endmodule

// File: tb/tb_io_master.sv
// Directed bench for io_master: four instances (OP = 0..3, POLL_MAX = 8)
// share clock, reset, start and a small peripheral model driven from the
// address of instance 0.
module tb_io_master;

`ifdef IO_MASTER_WAIT_ACK_EN
  localparam int AckExtra = 1;
`else
  localparam int AckExtra = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] rdata;

  logic        rd[4];
  logic        wr[4];
  logic [1:0]  ad[4];
  logic [11:0] wd[4];
  logic        bsy[4];
  logic        dn[4];
  logic        er[4];
  logic [11:0] res[4];

  logic        st_ready = 1'b0;
  logic        st_ack = 1'b0;
  logic [15:0] sw = 16'h1234;

  int total = 0;
  int bad = 0;
  int done_at = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    io_master #(
      .OP       (g),
      .POLL_MAX (8)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pRead      (rd[g]),
      .pWrite     (wr[g]),
      .addr       (ad[g]),
      .pWriteData (wd[g]),
      .pReadData  (rdata),
      .busy       (bsy[g]),
      .done       (dn[g]),
      .error      (er[g]),
      .result     (res[g])
    );
  end

  // Peripheral model: combinational read data.
  always_comb begin
    rdata = 32'h0;
    case (ad[0])
      2'b00:   rdata = {30'h0, st_ready, st_ack};
      2'b10:   rdata = {24'h0, sw[7:0]};
      2'b11:   rdata = {24'h0, sw[15:8]};
      default: rdata = 32'hDEAD_0000;
    endcase
  end

  // Bus monitor on instance 0.
  logic        mon_clr = 1'b0;
  int          wr_cnt = 0;
  int          poll_cnt = 0;
  int          done_cnt = 0;
  int          both_cnt = 0;
  logic [11:0] wr_data = '0;
  logic [1:0]  wr_addr = '0;

  always @(posedge clk) begin
    if (mon_clr) begin
      wr_cnt   <= 0;
      poll_cnt <= 0;
      done_cnt <= 0;
      both_cnt <= 0;
    end else begin
      if (wr[0]) begin
        wr_cnt  <= wr_cnt + 1;
        wr_data <= wd[0];
        wr_addr <= ad[0];
      end
      if (rd[0] && ad[0] == 2'b00) poll_cnt <= poll_cnt + 1;
      if (dn[0]) done_cnt <= done_cnt + 1;
      if (rd[0] && wr[0]) both_cnt <= both_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction; cycle 1 is the first cycle after the start-sampling edge.
  task automatic run_txn(input int ready_cyc, input int ack_cyc, input int pulse_cyc,
                         input int max_cyc);
    done_at  = 0;
    st_ready = (ready_cyc <= 1);
    st_ack   = (ack_cyc == 1);
    start    = 1'b1;
    mon_clr  = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    mon_clr = 1'b0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      if (cyc == ready_cyc) st_ready = 1'b1;
      if (cyc == ack_cyc) st_ack = 1'b1;
      start = (cyc == pulse_cyc);
      if (cyc == 1) begin
        check("busy_after_start", bsy[0], 1);
        check("error_cleared_on_start", er[0], 0);
      end
      if (dn[0] && done_at == 0) done_at = cyc;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    check("reset_outputs", {rd[0], wr[0], ad[0], wd[0], bsy[0], dn[0], er[0], res[0]}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Ready on first poll, switch 0x1234.
    sw = 16'h1234;
    run_txn(1, 1, 0, 12);
    check("t1_done_cycle", done_at, 6 + AckExtra);
    check("t1_done_count", done_cnt, 1);
    check("t1_write_count", wr_cnt, 1);
    check("t1_write_addr", wr_addr, 2'b01);
    check("t1_write_data", wr_data, 12'h046);
    check("t1_poll_count", poll_cnt, 1 + AckExtra);
    check("t1_rd_wr_overlap", both_cnt, 0);
    check("t1_result_add", res[0], 12'h046);
    check("t1_result_sub", res[1], 12'hFDE);
    check("t1_result_mul", res[2], 12'h3A8);
    check("t1_result_pass", res[3], 12'h234);
    check("t1_idle_busy", bsy[0], 0);

    // Ready on the 4th poll; start pulsed while busy.
    run_txn(4, 1, 3, 16);
    check("t2_done_cycle", done_at, 9 + AckExtra);
    check("t2_done_count", done_cnt, 1);
    check("t2_poll_count", poll_cnt, 4 + AckExtra);
    check("t2_no_retrigger", bsy[0], 0);

    // Status never ready: timeout after exactly 8 polls.
    run_txn(999, 1, 0, 14);
    check("t3_done_cycle", done_at, 0);
    check("t3_done_count", done_cnt, 0);
    check("t3_poll_count", poll_cnt, 8);
    check("t3_write_count", wr_cnt, 0);
    check("t3_error", er[0], 1);
    check("t3_result_kept", res[0], 12'h046);
    check("t3_idle_busy", bsy[0], 0);

    // Next start clears error; all-ones operands.
    sw = 16'hFFFF;
    run_txn(1, 1, 0, 12);
    check("t4_done_cycle", done_at, 6 + AckExtra);
    check("t4_error", er[0], 0);
    check("t4_write_data", wr_data, 12'h1FE);
    check("t4_result_add", res[0], 12'h1FE);
    check("t4_result_sub", res[1], 12'h000);
    check("t4_result_mul", res[2], 12'hE01);
    check("t4_result_pass", res[3], 12'hFFF);

`ifdef IO_MASTER_WAIT_ACK_EN
    // Ack arrives three cycles after the write.
    sw = 16'h1234;
    run_txn(1, 8, 0, 14);
    check("ack_done_cycle", done_at, 9);
    check("ack_write_count", wr_cnt, 1);
    check("ack_error", er[0], 0);

    // Ack never arrives: timeout with the LED already written.
    run_txn(1, 999, 0, 20);
    check("acktmo_done_cycle", done_at, 0);
    check("acktmo_write_count", wr_cnt, 1);
    check("acktmo_poll_count", poll_cnt, 9);
    check("acktmo_error", er[0], 1);
`endif

    // Asynchronous reset in RD_HI.
    sw       = 16'h1234;
    st_ready = 1'b1;
    start    = 1'b1;
    mon_clr  = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    mon_clr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_in_rd_hi_addr", ad[0], 2'b11);
    #2 reset = 1'b0;
    #1;
    check("rst_async_outputs", {rd[0], wr[0], ad[0], wd[0], bsy[0], dn[0], er[0], res[0]}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("rst_release_busy", bsy[0], 0);
    check("rst_no_write", wr_cnt, 0);
    check("rst_release_outputs", {rd[0], wr[0], ad[0], wd[0], dn[0], er[0], res[0]}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
